// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES
// equal slices, one slice resolved per register stage, under a valid/ready handshake.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_S,
  output logic             o_C,
  output logic             o_V,
  output logic             o_Z
);

  localparam int SEG = WIDTH / STAGES;

  logic en;

  // Stage registers: operands (B already conditionally inverted), partial sum, carry, valid.
  logic [WIDTH-1:0] a_reg     [STAGES];
  logic [WIDTH-1:0] b_reg     [STAGES];
  logic [WIDTH-1:0] s_reg     [STAGES];
  logic             c_reg     [STAGES];
  logic             valid_reg [STAGES];
  logic             v_reg;
  logic             z_reg;

  // Per-stage inputs (previous stage or ports) and next-state values.
  logic [WIDTH-1:0] a_in       [STAGES];
  logic [WIDTH-1:0] b_in       [STAGES];
  logic [WIDTH-1:0] s_in       [STAGES];
  logic             c_in       [STAGES];
  logic             valid_in   [STAGES];
  logic [WIDTH-1:0] s_next     [STAGES];
  logic             c_next     [STAGES];
  logic             v_next;
  logic             z_next;

  assign en      = !valid_reg[STAGES-1] || i_ready;
  assign o_ready = en;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [SEG:0]     slice_sum;
      logic [WIDTH-1:0] s_out;

      if (gi == 0) begin : g_first
        assign a_in[gi]     = i_A;
        assign b_in[gi]     = i_B ^ {WIDTH{i_sub}};
        assign s_in[gi]     = '0;
        assign c_in[gi]     = i_sub;
        assign valid_in[gi] = i_valid;
      end else begin : g_rest
        assign a_in[gi]     = a_reg[gi-1];
        assign b_in[gi]     = b_reg[gi-1];
        assign s_in[gi]     = s_reg[gi-1];
        assign c_in[gi]     = c_reg[gi-1];
        assign valid_in[gi] = valid_reg[gi-1];
      end

      assign slice_sum = {1'b0, a_in[gi][gi*SEG +: SEG]}
                       + {1'b0, b_in[gi][gi*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_in[gi]};

      always_comb begin
        s_out                 = s_in[gi];
        s_out[gi*SEG +: SEG]  = slice_sum[SEG-1:0];
      end

      assign s_next[gi] = s_out;
      assign c_next[gi] = slice_sum[SEG];

      // Flags are resolved alongside the final slice so they register with the result.
      if (gi == STAGES - 1) begin : g_last
        assign v_next = (a_in[gi][WIDTH-1] == b_in[gi][WIDTH-1]) &&
                        (s_out[WIDTH-1] != a_in[gi][WIDTH-1]);
        assign z_next = ~|s_out;
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
        s_reg[k]     <= '0;
        c_reg[k]     <= 1'b0;
      end
      v_reg <= 1'b0;
      z_reg <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= valid_in[k];
        a_reg[k]     <= a_in[k];
        b_reg[k]     <= b_in[k];
        s_reg[k]     <= s_next[k];
        c_reg[k]     <= c_next[k];
      end
      v_reg <= v_next;
      z_reg <= z_next;
    end
  end

  assign o_valid = valid_reg[STAGES-1];
  assign o_S     = s_reg[STAGES-1];
  assign o_C     = c_reg[STAGES-1];
  assign o_V     = v_reg;
  assign o_Z     = z_reg;

endmodule

// File: doc/pipe_adder.md
# pipe_adder

- Parametrised, pipelined two's-complement adder/subtractor, the successor to the team's 32-bit combinational `adder`.
- Splits the carry chain into `STAGES` equal slices, one slice per register stage, so wide datapaths close timing at full clock rate.
- Accepts one operation per cycle under a valid/ready handshake and returns the result with carry, overflow and zero flags.
- Sits between the execute-stage operand mux and the writeback stage.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits; must be a multiple of `STAGES`.
- `STAGES`, default 4: number of pipeline stages, ≥1. Slice width `SEG = WIDTH/STAGES`.

Ports:
- `i_clk`, input, 1: the single clock; all state updates on its rising edge.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_valid`, input, 1: input operation present.
- `o_ready`, output, 1: block can accept an input this cycle.
- `i_A`, input, `WIDTH`: operand A.
- `i_B`, input, `WIDTH`: operand B.
- `i_sub`, input, 1: 0 = A+B, 1 = A−B.
- `o_valid`, output, 1: result present on `o_S` and the flags.
- `i_ready`, input, 1: downstream accepts the result.
- `o_S`, output, `WIDTH`: sum or difference, modulo 2^WIDTH.
- `o_C`, output, 1: carry out of the MSB. For subtract, 1 means no borrow (A ≥ B unsigned).
- `o_V`, output, 1: signed overflow.
- `o_Z`, output, 1: `o_S` is zero.

## Operation
Input transfer:
- An input transfers on a rising edge where `i_valid && o_ready`.
- On transfer, `i_sub` is captured with the operands.

Arithmetic:
- Computes A + (B XOR {WIDTH{sub}}) + sub.
- Stage k (0-based) adds bits [k·SEG +: SEG] with the carry registered from stage k−1. Stage 0 carry-in = sub.

Skew and deskew registers:
- Unconsumed operand slices travel down the pipe with the operation.
- Completed sum slices travel to the output.
- At the output, all WIDTH bits of a result belong to the same operation.

Flags, for the operation presented at the output:
- `o_C` = carry out of bit WIDTH−1.
- `o_V` = carry into MSB XOR carry out of MSB, equivalently (A[MSB]==B'[MSB]) && (S[MSB]!=A[MSB]) where B' is the inverted-or-not B.
- `o_Z` = ~|o_S.

Per-stage valid and stall:
- Each stage has a valid bit.
- Bubbles (no transfer) propagate as valid=0. Data registers of invalid stages may hold any value; outputs other than `o_valid` are don't-care while `o_valid`=0.
- Global stall: `en = !o_valid || i_ready`. `o_ready = en`.
- When `en`=0, every stage register (valid and data) holds its value.
- When `en`=1, all stages advance one position.

Reset:
- Asserting `i_rst_n` low immediately clears every stage valid bit, `o_valid`, `o_S`, `o_C`, `o_V` and `o_Z` to 0.
- In-flight operations are discarded.
- `o_ready` is 1 while in reset, since `o_valid`=0; transfers are ignored until `i_rst_n` is high at a clock edge.

## Timing
- Latency: an operation transferred at edge n appears with `o_valid`=1 after edge n+STAGES−1. That is STAGES cycles from capture to first visibility, counting the capture edge as the first stage register.
  - STAGES=1 gives a registered single-cycle adder: result visible the cycle after transfer.
- Throughput: one operation per cycle while `i_ready`=1.
- Output hold: the output holds stable (`o_S`, flags, `o_valid`) for as long as `o_valid && !i_ready`.
- Stall and input acceptance:
  - `o_ready` is combinational from `o_valid` and `i_ready`.
  - No input is accepted during a stall, including when upstream stages hold bubbles; no bubble-collapsing.
- Simultaneous output acceptance and new input transfer in the same cycle is legal and keeps full throughput.
- Reset deassertion: the first transfer can occur at the first rising edge after `i_rst_n` goes high.

## Test plan
Each scenario runs at WIDTH=32, STAGES=4 unless stated.
- Basic add: A=10, B=20, sub=0, i_ready=1 → after 4 cycles, o_S=30, C=0, V=0, Z=0, o_valid high for exactly 1 cycle.
- Carry across slices: A=0x0000_FFFF, B=1, add → o_S=0x0001_0000 (carry ripples through stages 1→2). Also A=0xFFFF_FFFF, B=1 → o_S=0, C=1, Z=1, V=0.
- Subtract and overflow:
  - A=5, B=7, sub=1 → o_S=0xFFFF_FFFE, C=0.
  - A=0x7FFF_FFFF, B=1, add → o_S=0x8000_0000, V=1.
  - A=0x8000_0000, B=1, sub=1 → o_S=0x7FFF_FFFF, V=1, C=1.
- Back-to-back streaming with stall:
  - Issue 8 ops (A=i, B=100·i, alternating sub) every cycle.
  - Drop i_ready for 3 cycles mid-stream → o_ready low during the stall, output held constant.
  - Results emerge in order with no loss or duplication; total cycles = 8+3+3 after the first transfer.
- Reset mid-operation: issue 3 ops, assert i_rst_n low between clock edges → o_valid and all outputs 0 immediately. After release, a new op (A=1, B=2) yields 3 with no stale results.
- Parameter sweep: WIDTH=8/STAGES=1 and WIDTH=64/STAGES=8.
  - 1000 random ops with random i_valid/i_ready, compared against a reference model.
  - Latency = STAGES verified.
